regs_wb_arbiter: RTL and testbench
==================================

# regs_wb_arbiter

Write-back arbiter and scoreboard for the 32-entry register file. It shares the register file's single write port between two producers, the ALU (requester A) and the load unit (requester B), using valid/ready handshakes and round-robin arbitration. It drives registered write_en/write_reg/write_data into `regs`. It also keeps a per-register busy scoreboard so issue logic can stall on operands whose write-back is still pending.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- NREG, 32, number of architectural registers (2**ADDR_W)

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-high
- a_valid  in  1  ALU write-back request
- a_ready  out  1  ALU request accepted this cycle
- a_reg  in  ADDR_W  ALU destination register
- a_data  in  DATA_W  ALU result
- b_valid, b_ready, b_reg, b_data: same meaning for the load unit
- sb_set_en  in  1  issue marks a destination as pending
- sb_set_reg  in  ADDR_W  register to mark busy
- rs1, rs2  in  ADDR_W  operand indices to query
- rs1_busy, rs2_busy  out  1  combinational busy flag for rs1/rs2
- write_en  out  1  registered write enable to the register file
- write_reg  out  ADDR_W  registered write index
- write_data  out  DATA_W  registered write data
- wb_count  out  32  number of committed non-zero-register writes, saturating

## Operation
- Arbitration is combinational from valid and pointer `last`:
  - only one valid: that requester is granted;
  - both valid: the requester not named by `last` is granted.
- x_ready = grant_x. At most one ready per cycle. Ready never asserts without valid.
- Accept = valid && ready. On an accept edge:
  - write_reg and write_data load the granted requester's reg and data;
  - write_en loads 1 if the granted reg ≠ 0, else 0;
  - `last` loads the granted requester.
- If there is no accept, write_en loads 0 and write_reg/write_data hold.
- Register 0: writes are accepted and dropped, never busy, never counted.
- Scoreboard: NREG-bit vector, bit 0 tied to 0.
  - sb_set_en sets bit sb_set_reg.
  - An accept clears bit of the granted reg.
  - Set and clear of the same register in the same cycle: set wins, because a newer producer was issued.
- rsN_busy = busy[rsN]. This is purely combinational; there is no bypass of a same-cycle set.
- wb_count increments on each accept with reg ≠ 0 and saturates at 0xFFFF_FFFF.
- Requesters must hold reg/data stable while valid && !ready. The block does not check this.

## Timing
- Reset values:
  - write_en 0, write_reg 0, write_data 0;
  - busy all 0;
  - `last` = B, so A wins the first tie;
  - wb_count 0;
  - a_ready/b_ready 0 while rst is high.
- Latency: accept at edge N → write_en high during cycle N..N+1. The register file captures the write on the negedge inside that cycle, so a read issued at edge N+1 returns the new value.
- Busy clears at edge N, the accept edge. rsN_busy is low from cycle N onward, consistent with the read timing above.
- Continuous contention alternates strictly A, B, A, B. Neither requester waits more than one cycle.
- Throughput is one write per cycle.
- Reset mid-operation:
  - pending busy bits are lost;
  - any in-flight write_en is forced low immediately;
  - upstream requesters must re-present after reset.

## Structure
- Shared package `regs_pkg`: DATA_W/ADDR_W/NREG constants and the requester enum (REQ_A, REQ_B) used for `last`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with inputs req[1:0] and last, and output gnt[1:0]. Kept separate for reuse by the future read-port arbiter.
- Scoreboard, output register and counter stay in the top module.

## Test plan
- Reset, then A-only write of 0x1234_5678 to r5 → a_ready=1 that cycle; next cycle write_en=1, write_reg=5, write_data=0x1234_5678, wb_count=1.
- Sustained contention for 4 cycles, A→r1, B→r2 → grants A, B, A, B; write_en high 4 consecutive cycles.
- sb_set r7, then query rs1=7 → busy=1; B writes r7 → rs1_busy=0 on the cycle after accept. Same-cycle sb_set r7 and accept r7 → busy remains 1.
- A writes r0 with 0xFFFF_FFFF → a_ready=1, write_en=0, wb_count unchanged; rs1=0 never busy.
- Assert rst mid-stream with write_en=1 and busy r3 set → write_en=0 and busy[3]=0 immediately; the first tie after release grants A.
- Force wb_count to 0xFFFF_FFFE, perform 3 writes → count stops at 0xFFFF_FFFF.

Source files
------------

// File: rtl/regs_pkg.sv
// ---------------------------------------------------------------------------
// regs_pkg
// Shared constants and types for the register-file write-back path.
//   DATA_W : width of a register value
//   ADDR_W : width of a register index
//   NREG   : number of architectural registers
//   req_e  : identifies a write-back requester (ALU = REQ_A, load = REQ_B)
// ---------------------------------------------------------------------------
package regs_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 2 ** ADDR_W;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_e;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req[1:0] : request lines, bit 0 = requester A, bit 1 = requester B
//   last     : requester that won the most recent accepted transfer
//   gnt[1:0] : one-hot (or zero) grant, same bit order as req
// ---------------------------------------------------------------------------
module rr_arb2
   import regs_pkg::*;
(
   input  logic [1:0] req,
   input  req_e       last,
   output logic [1:0] gnt
);

   // A lone request is granted directly; on a tie the requester that did
   // not win last time goes first, which gives strict alternation under
   // continuous contention.
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last == REQ_B) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/regs_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regs_wb_arbiter
// Shares the register file's single write port between the ALU (A) and the
// load unit (B), and tracks which registers still have a write-back pending.
//   clk, rst                 : clock, asynchronous active-high reset
//   a_valid/a_ready/a_reg/a_data : ALU write-back handshake
//   b_valid/b_ready/b_reg/b_data : load-unit write-back handshake
//   sb_set_en, sb_set_reg    : issue marks a destination register busy
//   rs1, rs2 / rs1_busy, rs2_busy : combinational busy queries
//   write_en/write_reg/write_data : registered write port into the regfile
//   wb_count                 : saturating count of non-r0 writes committed
// ---------------------------------------------------------------------------
module regs_wb_arbiter
   import regs_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_reg,
   input  logic [DATA_W-1:0] b_data,
   input  logic              sb_set_en,
   input  logic [ADDR_W-1:0] sb_set_reg,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic [31:0]       wb_count
);

   logic [1:0]        req;
   logic [1:0]        gnt;
   req_e              last;
   logic              grant_b;
   logic              accept;
   logic              accept_nz;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_next;
   logic [31:0]       count_q;

   assign req = {b_valid, a_valid};

   rr_arb2 u_arb (
      .req  (req),
      .last (last),
      .gnt  (gnt)
   );

   // Ready is suppressed while reset is held so nothing is accepted then.
   assign a_ready   = gnt[0] & ~rst;
   assign b_ready   = gnt[1] & ~rst;
   assign grant_b   = b_ready;
   assign accept    = (a_valid & a_ready) | (b_valid & b_ready);
   assign sel_reg   = grant_b ? b_reg  : a_reg;
   assign sel_data  = grant_b ? b_data : a_data;
   assign accept_nz = accept && (sel_reg != '0);

   // Next busy vector: the accepted write clears its bit first, then a new
   // issue sets its bit, so a newer producer for the same register keeps it
   // busy. Register 0 can never be busy.
   always_comb begin
      busy_next = busy;
      if (accept_nz) begin
         busy_next[sel_reg] = 1'b0;
      end
      if (sb_set_en) begin
         busy_next[sb_set_reg] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   assign rs1_busy = busy[rs1];
   assign rs2_busy = busy[rs2];
   assign wb_count = count_q;

   // Write port register, round-robin pointer, scoreboard and counter.
   // Writes to r0 are accepted but leave write_en low and are not counted;
   // with no accept the write index/data simply hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_en   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         last       <= REQ_B;
         busy       <= '0;
         count_q    <= '0;
      end else begin
         busy     <= busy_next;
         write_en <= accept_nz;
         if (accept) begin
            write_reg  <= sel_reg;
            write_data <= sel_data;
            last       <= grant_b ? REQ_B : REQ_A;
         end
         if (accept_nz && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regs_wb_arbiter
// Directed bench for regs_wb_arbiter. Each issued request pushes its expected
// register-file write into a queue; a monitor pops and compares whenever the
// DUT raises write_en.
// ---------------------------------------------------------------------------
module tb_regs_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [4:0]  a_reg = '0;
   logic [31:0] a_data = '0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [4:0]  b_reg = '0;
   logic [31:0] b_data = '0;
   logic        sb_set_en = 1'b0;
   logic [4:0]  sb_set_reg = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        write_en;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [31:0] wb_count;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
      logic [31:0] c;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_count = '0;

   regs_wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_reg      (a_reg),
      .a_data     (a_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_reg      (b_reg),
      .b_data     (b_data),
      .sb_set_en  (sb_set_en),
      .sb_set_reg (sb_set_reg),
      .rs1        (rs1),
      .rs2        (rs2),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .write_en   (write_en),
      .write_reg  (write_reg),
      .write_data (write_data),
      .wb_count   (wb_count)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   // Drives one cycle of requests on the negedge, checks the grant, records
   // the expected write, then checks write_en just after the accept edge.
   task automatic apply_stimulus(input string name,
                                 input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] br, input logic [31:0] bd,
                                 input logic se, input logic [4:0] sr,
                                 input logic ega, input logic egb);
      exp_t       e;
      logic [4:0] gr;
      @(negedge clk);
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      sb_set_en = se; sb_set_reg = sr;
      #1;
      check_output({name, "_a_ready"}, {31'd0, a_ready}, {31'd0, ega});
      check_output({name, "_b_ready"}, {31'd0, b_ready}, {31'd0, egb});
      gr = egb ? br : ar;
      if ((ega || egb) && gr != 5'd0) begin
         if (exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 32'd1;
         e.r = gr;
         e.d = egb ? bd : ad;
         e.c = exp_count;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      check_output({name, "_write_en"}, {31'd0, write_en}, {31'd0, (ega || egb) && gr != 5'd0});
      a_valid = 1'b0; b_valid = 1'b0; sb_set_en = 1'b0;
   endtask

   // Monitor: every committed write must match the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (write_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_output("wb_unexpected", {27'd0, write_reg}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check_output("wb_reg", {27'd0, write_reg}, {27'd0, e.r});
            check_output("wb_data", write_data, e.d);
            check_output("wb_count", wb_count, e.c);
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state, with both requesters pushing to prove ready stays low.
      #1 rst = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1;
      #2;
      check_output("rst_write_en", {31'd0, write_en}, 32'd0);
      check_output("rst_write_reg", {27'd0, write_reg}, 32'd0);
      check_output("rst_write_data", write_data, 32'd0);
      check_output("rst_wb_count", wb_count, 32'd0);
      check_output("rst_a_ready", {31'd0, a_ready}, 32'd0);
      check_output("rst_b_ready", {31'd0, b_ready}, 32'd0);
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Single ALU write, then a single load write so the pointer names B.
      apply_stimulus("a_only", 1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
      check_output("a_only_count", wb_count, 32'd1);
      apply_stimulus("b_only", 0, 5'd0, 32'd0, 1, 5'd6, 32'hB0B0_0006, 0, 5'd0, 0, 1);

      // Sustained contention alternates A, B, A, B.
      apply_stimulus("tie0", 1, 5'd1, 32'hA000_0001, 1, 5'd2, 32'hB000_0002, 0, 5'd0, 1, 0);
      apply_stimulus("tie1", 1, 5'd1, 32'hA000_0011, 1, 5'd2, 32'hB000_0012, 0, 5'd0, 0, 1);
      apply_stimulus("tie2", 1, 5'd1, 32'hA000_0021, 1, 5'd2, 32'hB000_0022, 0, 5'd0, 1, 0);
      apply_stimulus("tie3", 1, 5'd1, 32'hA000_0031, 1, 5'd2, 32'hB000_0032, 0, 5'd0, 0, 1);

      // Scoreboard set, clear by write-back, and set-wins on collision.
      rs1 = 5'd7;
      apply_stimulus("sb_set", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 0, 0);
      check_output("sb_busy_after_set", {31'd0, rs1_busy}, 32'd1);
      apply_stimulus("sb_clear", 0, 5'd0, 32'd0, 1, 5'd7, 32'h0000_0777, 0, 5'd0, 0, 1);
      check_output("sb_busy_after_wb", {31'd0, rs1_busy}, 32'd0);
      apply_stimulus("sb_pre", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 0, 0);
      apply_stimulus("sb_collide", 1, 5'd7, 32'h0000_7777, 0, 5'd0, 32'd0, 1, 5'd7, 1, 0);
      check_output("sb_set_wins", {31'd0, rs1_busy}, 32'd1);

      // Register 0: accepted, dropped, never busy, not counted.
      rs2 = 5'd0;
      apply_stimulus("r0_write", 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 1, 5'd0, 1, 0);
      check_output("r0_count", wb_count, exp_count);
      check_output("r0_busy", {31'd0, rs2_busy}, 32'd0);

      // Mid-stream reset with a write in flight and r3 pending.
      rs1 = 5'd3;
      apply_stimulus("pre_rst", 1, 5'd4, 32'h4444_4444, 0, 5'd0, 32'd0, 1, 5'd3, 1, 0);
      check_output("pre_rst_busy", {31'd0, rs1_busy}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check_output("mid_rst_write_en", {31'd0, write_en}, 32'd0);
      check_output("mid_rst_busy", {31'd0, rs1_busy}, 32'd0);
      check_output("mid_rst_count", wb_count, 32'd0);
      exp_count = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      apply_stimulus("post_rst_tie", 1, 5'd8, 32'h8888_0008, 1, 5'd9, 32'h9999_0009, 0, 5'd0, 1, 0);

      // Saturation of the write counter.
      @(negedge clk);
      force dut.count_q = 32'hFFFF_FFFE;
      #1 release dut.count_q;
      exp_count = 32'hFFFF_FFFE;
      check_output("sat_preload", wb_count, 32'hFFFF_FFFE);
      apply_stimulus("sat0", 1, 5'd10, 32'h0000_000A, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
      apply_stimulus("sat1", 1, 5'd11, 32'h0000_000B, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
      apply_stimulus("sat2", 1, 5'd12, 32'h0000_000C, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
      check_output("sat_final", wb_count, 32'hFFFF_FFFF);

      // Every expected write must have been observed.
      repeat (3) @(posedge clk);
      #2;
      check_output("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
